// File: rtl/named_ports_out_fifo.sv
// Output FIFO behind named_ports_test: valid/ready capture, first-word-fall-through
// delivery, plus a popped-byte checksum and a saturating backpressure-stall counter.
module named_ports_out_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic [DATA_W-1:0] checksum,
  output logic [7:0]        stall_cnt,
  input  logic              clr_stats
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [7:0]      STALL_MAX = 8'hFF;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic [7:0]        stall_q, stall_d;

  logic push, pop, stall;

  // Readiness depends only on registered count, so a pop never frees a slot
  // for a push in the same cycle.
  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

  assign push  = in_valid & in_ready;
  assign pop   = out_valid & out_ready;
  assign stall = in_valid & ~in_ready;

  assign count     = count_q;
  assign checksum  = checksum_q;
  assign stall_cnt = stall_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    checksum_d = checksum_q;
    stall_d    = stall_q;

    if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);

    if (push && !pop)      count_d = count_q + (ADDR_W + 1)'(1);
    else if (pop && !push) count_d = count_q - (ADDR_W + 1)'(1);

    // A clear restarts the statistics with whatever this cycle contributes.
    if (clr_stats) begin
      checksum_d = pop ? out_data : '0;
      stall_d    = stall ? 8'd1 : 8'd0;
    end else begin
      if (pop)                          checksum_d = checksum_q + out_data;
      if (stall && stall_q != STALL_MAX) stall_d   = stall_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      checksum_q <= '0;
      stall_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      checksum_q <= checksum_d;
      stall_q    <= stall_d;
    end
  end

  // Storage needs no reset: entries are only observable once count covers them.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_named_ports_out_fifo.sv
// Directed + randomized bench for named_ports_out_fifo, checked against a queue model.
module tb_named_ports_out_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [2:0] count;
  logic [7:0] checksum;
  logic [7:0] stall_cnt;
  logic       clr_stats;

  named_ports_out_fifo #(.DATA_W(8), .DEPTH(4), .ADDR_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .checksum  (checksum),
    .stall_cnt (stall_cnt),
    .clr_stats (clr_stats)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a FIFO of bytes plus the two statistics.
  logic [7:0] mq[$];
  logic [7:0] m_chk;
  logic [7:0] m_stall;

  task automatic model_reset();
    mq.delete();
    m_chk   = 8'h00;
    m_stall = 8'h00;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [7:0] head;
    head = (mq.size() != 0) ? mq[0] : 8'h00;
    chk("in_ready",  32'(in_ready),  32'(mq.size() != 4));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("out_data",  32'(out_data),  32'(head));
    chk("count",     32'(count),     32'(mq.size()));
    chk("checksum",  32'(checksum),  32'(m_chk));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
  endtask

  // Entered just after a falling edge; returns at the next falling edge.
  task automatic cycle(input logic iv, input logic [7:0] d, input logic ordy, input logic clr);
    logic       push, pop, st;
    logic [7:0] head;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    clr_stats = clr;
    #1 check_all();
    push = iv && (mq.size() != 4);
    pop  = ordy && (mq.size() != 0);
    st   = iv && (mq.size() == 4);
    head = (mq.size() != 0) ? mq[0] : 8'h00;
    @(posedge clk);
    if (pop)  void'(mq.pop_front());
    if (push) mq.push_back(d);
    if (clr) begin
      m_chk   = pop ? head : 8'h00;
      m_stall = st ? 8'd1 : 8'd0;
    end else begin
      if (pop) m_chk = m_chk + head;
      if (st && m_stall != 8'hFF) m_stall = m_stall + 8'd1;
    end
    @(negedge clk);
  endtask

  // Reset asserted in the middle of the low clock phase; effect must be immediate.
  task automatic mid_reset(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr_stats = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_count"},     32'(count),     32'd0);
    chk({tag, "_checksum"},  32'(checksum),  32'd0);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
    chk({tag, "_out_data"},  32'(out_data),  32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] fill3 [4];
    logic [7:0] drain4 [4];
    logic [7:0] fill5 [4];
    logic [7:0] d;
    logic       iv_prev, rdy_prev;

    fill3  = '{8'hA5, 8'h5A, 8'hFF, 8'h01};
    drain4 = '{8'h5A, 8'hFF, 8'h01, 8'h77};
    fill5  = '{8'hFF, 8'hFF, 8'h03, 8'h10};

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; clr_stats = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_stall",     32'(stall_cnt), 32'd0);
    rst = 1'b0;

    // Mid-run reset with three bytes held.
    cycle(1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0);
    cycle(1'b1, 8'h33, 1'b0, 1'b0);
    chk("s1_count_pre", 32'(count), 32'd3);
    mid_reset("s1");
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Two pushes, then two pops.
    cycle(1'b1, 8'h12, 1'b0, 1'b0);
    chk("s2_first_visible", 32'(out_data), 32'h12);
    cycle(1'b1, 8'h34, 1'b0, 1'b0);
    chk("s2_count", 32'(count), 32'd2);
    chk("s2_head",  32'(out_data), 32'h12);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("s2_checksum", 32'(checksum), 32'h46);
    chk("s2_count0",   32'(count), 32'd0);

    // Fill to full, then stall three cycles.
    for (int i = 0; i < 4; i++) cycle(1'b1, fill3[i], 1'b0, 1'b0);
    chk("s3_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h77, 1'b0, 1'b0);
    chk("s3_stall", 32'(stall_cnt), 32'd3);
    chk("s3_count", 32'(count), 32'd4);

    // Pop while full refuses the simultaneous push; next cycle it is accepted.
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    chk("s4_count3", 32'(count), 32'd3);
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    chk("s4_count4", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("s4_order", 32'(out_data), 32'(drain4[i]));
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end

    // Checksum wrap and clear-with-pop.
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, fill5[i], 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("s5_wrap", 32'(checksum), 32'h01);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    chk("s5_clr_pop", 32'(checksum), 32'h10);

    // Stall counter saturation.
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 270; i++) cycle(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("stall_sat", 32'(stall_cnt), 32'd255);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Streaming: count settles at 1, no stalls.
    cycle(1'b1, 8'h40, 1'b1, 1'b1);
    for (int i = 1; i < 20; i++) begin
      chk("s6_count", 32'(count), 32'd1);
      chk("s6_data",  32'(out_data), 32'(8'h40 + i - 1));
      cycle(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
    end
    chk("s6_stall", 32'(stall_cnt), 32'd0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Randomized traffic; producer holds data while stalled.
    iv_prev = 1'b0; rdy_prev = 1'b1; d = 8'h00;
    for (int i = 0; i < 400; i++) begin
      logic iv;
      if (i == 200) mid_reset("rnd_rst");
      if (iv_prev && !rdy_prev) iv = 1'b1;
      else begin
        iv = ($urandom_range(0, 3) != 0);
        d  = 8'($urandom);
      end
      rdy_prev = (mq.size() != 4);
      iv_prev  = iv;
      cycle(iv, d, ($urandom_range(0, 2) != 0), ($urandom_range(0, 31) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
